// File: rtl/fft_pkg.sv
// Shared definitions for the OFDM FFT datapath: default widths, the phase
// encoding produced by the twiddle ROM, and a complex sample type.
package fft_pkg;

  localparam int FFT_DATA_W = 24;
  localparam int FFT_FRAC_W = 8;

  // Phase reported by the twiddle ROM alongside each sample.
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_BFLY = 2'd1,
    ST_TWID = 2'd2,
    ST_ILL  = 2'd3
  } bfly_state_t;

  // Complex sample at the default datapath width.
  typedef struct packed {
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/sdf_bfly_stage_4_if.sv
// Sample stream into and out of one SDF butterfly stage. The upstream side
// (ROM + sample source) is the master; the butterfly stage is the slave.
interface sdf_bfly_stage_4_if
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W
);

  logic                     in_valid;
  logic signed [DATA_W-1:0] din_r;
  logic signed [DATA_W-1:0] din_i;
  logic [1:0]               state;
  logic signed [DATA_W-1:0] w_r;
  logic signed [DATA_W-1:0] w_i;
  logic                     out_valid;
  logic signed [DATA_W-1:0] dout_r;
  logic signed [DATA_W-1:0] dout_i;

  modport master (
    output in_valid, din_r, din_i, state, w_r, w_i,
    input  out_valid, dout_r, dout_i
  );

  modport slave (
    input  in_valid, din_r, din_i, state, w_r, w_i,
    output out_valid, dout_r, dout_i
  );

endinterface

// File: rtl/cmul_fx.sv
// Combinational fixed-point complex multiplier. Each partial product is taken
// at full width, arithmetically shifted down by FRAC_W (floor), truncated to
// DATA_W bits, then combined with wrapping add/subtract.
module cmul_fx
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int FRAC_W = FFT_FRAC_W
) (
  input  logic signed [DATA_W-1:0] a_r,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_r,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] p_r,
  output logic signed [DATA_W-1:0] p_i
);

  localparam int PW = 2 * DATA_W;

  // Exact signed product at twice the operand width.
  function automatic logic signed [PW-1:0] mul_full(
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] y
  );
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ye;
    xe = PW'(x);
    ye = PW'(y);
    return xe * ye;
  endfunction

  // Drop the fractional bits toward -inf and keep the low DATA_W bits.
  function automatic logic signed [DATA_W-1:0] shift_trunc(
    input logic signed [PW-1:0] p
  );
    return DATA_W'(p >>> FRAC_W);
  endfunction

  logic signed [DATA_W-1:0] ac;
  logic signed [DATA_W-1:0] bd;
  logic signed [DATA_W-1:0] ad;
  logic signed [DATA_W-1:0] bc;

  // Scaled partial products, then the real/imag combination with wrap.
  always_comb begin
    ac  = shift_trunc(mul_full(a_r, b_r));
    bd  = shift_trunc(mul_full(a_i, b_i));
    ad  = shift_trunc(mul_full(a_r, b_i));
    bc  = shift_trunc(mul_full(a_i, b_r));
    p_r = ac - bd;
    p_i = ad + bc;
  end

endmodule

// File: rtl/sdf_bfly_stage_4.sv
// Radix-2 SDF decimation-in-frequency butterfly stage. A DEPTH-entry complex
// delay line feeds back the first half-frame; the ROM phase selects between
// filling, emitting sums (storing differences) and emitting twiddled
// differences (storing the next frame's first half). One-cycle latency.
module sdf_bfly_stage_4
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int FRAC_W = FFT_FRAC_W,
  parameter int DEPTH  = 4
) (
  input logic               clk,
  input logic               rst,
  sdf_bfly_stage_4_if.slave bus
);

  // Two's-complement add/subtract at datapath width; overflow wraps.
  function automatic logic signed [DATA_W-1:0] wrap_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return a + b;
  endfunction

  function automatic logic signed [DATA_W-1:0] wrap_sub(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return a - b;
  endfunction

  // Delay line: index 0 is the oldest entry (D), DEPTH-1 receives writes.
  logic signed [DATA_W-1:0] dly_r [DEPTH];
  logic signed [DATA_W-1:0] dly_i [DEPTH];

  logic signed [DATA_W-1:0] prod_r_p0;
  logic signed [DATA_W-1:0] prod_i_p0;
  logic signed [DATA_W-1:0] wr_r_p0;
  logic signed [DATA_W-1:0] wr_i_p0;
  logic signed [DATA_W-1:0] nxt_r_p0;
  logic signed [DATA_W-1:0] nxt_i_p0;
  logic                     vld_p0;

  logic signed [DATA_W-1:0] dout_r_p1;
  logic signed [DATA_W-1:0] dout_i_p1;
  logic                     vld_p1;

  cmul_fx #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_cmul (
    .a_r (dly_r[0]),
    .a_i (dly_i[0]),
    .b_r (bus.w_r),
    .b_i (bus.w_i),
    .p_r (prod_r_p0),
    .p_i (prod_i_p0)
  );

  // Phase decode: pick the output candidate and the value fed back into the line.
  always_comb begin
    wr_r_p0  = bus.din_r;
    wr_i_p0  = bus.din_i;
    nxt_r_p0 = dout_r_p1;
    nxt_i_p0 = dout_i_p1;
    vld_p0   = 1'b0;
    case (bus.state)
      ST_BFLY: begin
        nxt_r_p0 = wrap_add(dly_r[0], bus.din_r);
        nxt_i_p0 = wrap_add(dly_i[0], bus.din_i);
        wr_r_p0  = wrap_sub(dly_r[0], bus.din_r);
        wr_i_p0  = wrap_sub(dly_i[0], bus.din_i);
        vld_p0   = 1'b1;
      end
      ST_TWID: begin
        nxt_r_p0 = prod_r_p0;
        nxt_i_p0 = prod_i_p0;
        vld_p0   = 1'b1;
      end
      default: begin
        // Fill and the unused encoding both just store the sample.
      end
    endcase
  end

  // ---- stage p0 -> p1: register outputs and advance the line on accepted samples ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      dout_r_p1 <= '0;
      dout_i_p1 <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dly_r[k] <= '0;
        dly_i[k] <= '0;
      end
    end else begin
      vld_p1 <= bus.in_valid & vld_p0;
      if (bus.in_valid) begin
        dout_r_p1 <= nxt_r_p0;
        dout_i_p1 <= nxt_i_p0;
        for (int k = 0; k < DEPTH - 1; k++) begin
          dly_r[k] <= dly_r[k+1];
          dly_i[k] <= dly_i[k+1];
        end
        dly_r[DEPTH-1] <= wr_r_p0;
        dly_i[DEPTH-1] <= wr_i_p0;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.dout_r    = dout_r_p1;
  assign bus.dout_i    = dout_i_p1;

endmodule

// File: tb/tb_sdf_bfly_stage_4.sv
// Bench for sdf_bfly_stage_4: table-driven ramp frame plus hand sequences,
// with a scoreboard queue of expected per-cycle outputs.
module tb_sdf_bfly_stage_4;
  import fft_pkg::*;

  typedef struct {
    logic        r;
    logic        v;
    logic [1:0]  st;
    logic [23:0] xr;
    logic [23:0] xi;
    logic [23:0] wr;
    logic [23:0] wi;
    logic        ev;
    logic [23:0] er;
    logic [23:0] ei;
  } vec_t;

  typedef struct {
    logic        vld;
    logic [23:0] r;
    logic [23:0] i;
    int          id;
  } exp_t;

  logic clk;
  logic rst;
  sdf_bfly_stage_4_if #(.DATA_W(24)) bus ();

  sdf_bfly_stage_4 #(.DATA_W(24), .FRAC_W(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          step     = 0;
  logic [23:0] hold_r   = '0;
  logic [23:0] hold_i   = '0;
  vec_t        tbl[12];
  vec_t        t;

  localparam logic [23:0] W1  = 24'h000100;
  localparam logic [23:0] WP  = 24'h0000B5;
  localparam logic [23:0] WN  = 24'hFFFF4B;

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] st,
                              input logic [23:0] xr, input logic [23:0] xi,
                              input logic [23:0] wr, input logic [23:0] wi,
                              input logic ev, input logic [23:0] er, input logic [23:0] ei);
    vec_t o;
    o.r = r; o.v = v; o.st = st; o.xr = xr; o.xi = xi; o.wr = wr; o.wi = wi;
    o.ev = ev; o.er = er; o.ei = ei;
    return o;
  endfunction

  task automatic chk(input string nm, input int id, input logic [23:0] got, input logic [23:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s step %0d got %h want %h", nm, id, got, want);
    end
  endtask

  // Drive one cycle at the falling edge and queue what must appear after the next rising edge.
  task automatic drive(input vec_t d);
    exp_t e;
    @(negedge clk);
    rst          = d.r;
    bus.in_valid = d.v;
    bus.state    = d.st;
    bus.din_r    = d.xr;
    bus.din_i    = d.xi;
    bus.w_r      = d.wr;
    bus.w_i      = d.wi;
    if (d.r) begin
      hold_r = '0; hold_i = '0; e.vld = 1'b0;
    end else if (d.v && d.ev) begin
      hold_r = d.er; hold_i = d.ei; e.vld = 1'b1;
    end else begin
      e.vld = 1'b0;
    end
    e.r  = hold_r;
    e.i  = hold_i;
    e.id = step;
    step++;
    sb.push_back(e);
  endtask

  task automatic idle();
    drive(mk(0, 0, ST_BFLY, 24'h0ABCDE, 24'h012345, W1, 24'h0, 0, 0, 0));
  endtask

  // Compare DUT outputs shortly after each rising edge against the queued expectation.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("out_valid", mon_e.id, {23'b0, bus.out_valid}, {23'b0, mon_e.vld});
      chk("dout_r", mon_e.id, bus.dout_r, mon_e.r);
      chk("dout_i", mon_e.id, bus.dout_i, mon_e.i);
    end
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.state = ST_FILL;
    bus.din_r = '0; bus.din_i = '0; bus.w_r = '0; bus.w_i = '0;

    // Ramp frame x_k = k+1 followed by four zero drain samples with the stage-4 twiddles.
    tbl[0]  = mk(0, 1, ST_FILL, 24'h000100, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, ST_FILL, 24'h000200, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, ST_FILL, 24'h000300, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, ST_FILL, 24'h000400, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 1, ST_BFLY, 24'h000500, 0, 0, 0, 1, 24'h000600, 0);
    tbl[5]  = mk(0, 1, ST_BFLY, 24'h000600, 0, 0, 0, 1, 24'h000800, 0);
    tbl[6]  = mk(0, 1, ST_BFLY, 24'h000700, 0, 0, 0, 1, 24'h000A00, 0);
    tbl[7]  = mk(0, 1, ST_BFLY, 24'h000800, 0, 0, 0, 1, 24'h000C00, 0);
    tbl[8]  = mk(0, 1, ST_TWID, 0, 0, W1, 24'h0, 1, 24'hFFFC00, 24'h000000);
    tbl[9]  = mk(0, 1, ST_TWID, 0, 0, WP, WP,    1, 24'hFFFD2C, 24'hFFFD2C);
    tbl[10] = mk(0, 1, ST_TWID, 0, 0, 24'h0, W1, 1, 24'h000000, 24'hFFFC00);
    tbl[11] = mk(0, 1, ST_TWID, 0, 0, WN, WP,    1, 24'h0002D4, 24'hFFFD2C);

    // Reset state, with in_valid high to show reset wins.
    drive(mk(1, 1, ST_BFLY, 24'h000100, 0, 0, 0, 0, 0, 0));
    drive(mk(1, 0, ST_FILL, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 12; i++) drive(tbl[i]);
    idle();

    // Stall of three cycles inside the butterfly phase; state/w garbage must be ignored.
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        idle(); idle(); idle();
      end
      drive(tbl[i]);
    end

    // Back-to-back frames: the second frame's first half rides in the twiddle phase.
    for (int i = 0; i < 8; i++) drive(tbl[i]);
    for (int i = 8; i < 12; i++) begin
      t = tbl[i];
      t.xr = tbl[i-8].xr;
      drive(t);
    end
    for (int i = 4; i < 12; i++) drive(tbl[i]);

    // Overflow wrap: 0x7FFFFF + 1 wraps; stored difference 0x7FFFFE comes back through W=1.
    drive(mk(0, 1, ST_FILL, 24'h7FFFFF, 0, 0, 0, 0, 0, 0));
    drive(mk(0, 1, ST_FILL, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(0, 1, ST_FILL, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(0, 1, ST_FILL, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(0, 1, ST_BFLY, 24'h000001, 0, 0, 0, 1, 24'h800000, 0));
    for (int i = 0; i < 3; i++) drive(mk(0, 1, ST_BFLY, 0, 0, 0, 0, 1, 0, 0));
    drive(mk(0, 1, ST_TWID, 0, 0, W1, 0, 1, 24'h7FFFFE, 0));
    for (int i = 0; i < 3; i++) drive(mk(0, 1, ST_TWID, 0, 0, W1, 0, 1, 0, 0));

    // Illegal phase: no output, sample stored and seen as D four valid cycles later.
    drive(mk(0, 1, ST_ILL, 24'h000100, 24'h000010, 0, 0, 0, 0, 0));
    idle();
    for (int i = 0; i < 3; i++) drive(mk(0, 1, ST_FILL, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(0, 1, ST_BFLY, 0, 0, 0, 0, 1, 24'h000100, 24'h000010));
    for (int i = 0; i < 3; i++) drive(mk(0, 1, ST_BFLY, 0, 0, 0, 0, 1, 0, 0));
    drive(mk(0, 1, ST_TWID, 0, 0, W1, 0, 1, 24'h000100, 24'h000010));
    for (int i = 0; i < 3; i++) drive(mk(0, 1, ST_TWID, 0, 0, W1, 0, 1, 0, 0));

    // Reset mid-frame with a loaded line: outputs clear and the line reads back zero.
    for (int i = 0; i < 5; i++) drive(tbl[i]);
    drive(mk(1, 1, ST_BFLY, 24'h000600, 0, 0, 0, 0, 0, 0));
    drive(mk(0, 1, ST_TWID, 0, 0, W1, 0, 1, 0, 0));
    for (int i = 0; i < 12; i++) drive(tbl[i]);
    idle();
    idle();

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain pending=%0d required 0", sb.size());
    end
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
